// File: rtl/ready_valid_fifo.sv
// First-word-fall-through ready/valid FIFO with saturating transfer counters
// and a sticky check for upstream masters that withdraw or alter a stalled word.
module ready_valid_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int LW     = $clog2(DEPTH) + 1
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              clr_stats,
    output logic [LW-1:0]     level,
    output logic [CNT_W-1:0]  in_count,
    output logic [CNT_W-1:0]  out_count,
    output logic              proto_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              err_q, err_d;
    logic              stall_q, stall_d;
    logic [DATA_W-1:0] hist_data_q, hist_data_d;
    logic              push, pop;

    assign s_ready   = (level_q != LW'(DEPTH)) && !irst;
    assign m_valid   = (level_q != '0);
    assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level     = level_q;
    assign in_count  = in_cnt_q;
    assign out_count = out_cnt_q;
    assign proto_err = err_q;

    assign push = s_valid && s_ready;
    assign pop  = m_valid && m_ready;

    always_comb begin
        // Power-of-two depth lets the pointers wrap by natural overflow.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);

        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (push && (in_cnt_q != '1))  in_cnt_d  = in_cnt_q + CNT_W'(1);
        if (pop  && (out_cnt_q != '1)) out_cnt_d = out_cnt_q + CNT_W'(1);

        // A stalled word must stay valid and stable until it is accepted.
        err_d = err_q | (stall_q && (!s_valid || (s_data != hist_data_q)));

        if (clr_stats) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            err_d     = 1'b0;
        end

        stall_d     = s_valid && !s_ready;
        hist_data_d = s_data;
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
            hist_data_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
            hist_data_q <= hist_data_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end
endmodule

// File: tb/tb_ready_valid_fifo.sv
// Scoreboarded bench for ready_valid_fifo: fill, drain, streaming, protocol
// flag, counter saturation and asynchronous reset mid-operation.
module tb_ready_valid_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              iclk = 1'b0;
    logic              irst;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              clr_stats;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  in_count;
    logic [CNT_W-1:0]  out_count;
    logic              proto_err;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DATA_W-1:0] sb [$];

    ready_valid_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iclk(iclk), .irst(irst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_stats(clr_stats),
        .level(level), .in_count(in_count), .out_count(out_count), .proto_err(proto_err)
    );

    always #5 iclk = ~iclk;

    // Handshakes are sampled mid-cycle; they complete at the following posedge.
    always @(negedge iclk) begin
        if (irst) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: m_data=%h, expected no output", m_data);
                end else begin
                    logic [DATA_W-1:0] exp;
                    exp = sb.pop_front();
                    if (m_data !== exp) begin
                        n_fail++;
                        $display("FAIL sb_order: m_data=%h, expected %h", m_data, exp);
                    end
                end
            end
            if (s_valid && s_ready) sb.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_pulse();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    task automatic test_reset();
        irst = 1'b1; s_data = '0; s_valid = 1'b0; m_ready = 1'b0; clr_stats = 1'b0;
        tick();
        tick();
        chk("rst_level", level, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_in_count", in_count, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_proto_err", proto_err, 0);
        irst = 1'b0;
        #1;
        chk("rst_release_s_ready", s_ready, 1);
    endtask

    task automatic test_fill();
        logic [DATA_W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = vals[i];
            tick();
            if (i == 0) begin
                chk("fill_fwft_m_valid", m_valid, 1);
                chk("fill_fwft_m_data", m_data, 8'h11);
            end
        end
        chk("fill_level", level, 4);
        chk("fill_s_ready", s_ready, 0);
        chk("fill_in_count", in_count, 4);
        s_data = 8'h55;
        tick();
        tick();
        chk("fill_held_level", level, 4);
        chk("fill_held_in_count", in_count, 4);
        chk("fill_held_no_err", proto_err, 0);
        chk("fill_head_m_data", m_data, 8'h11);
    endtask

    task automatic test_proto();
        s_valid = 1'b0;
        tick();
        chk("proto_err_set", proto_err, 1);
        tick();
        chk("proto_err_sticky", proto_err, 1);
        clr_pulse();
        chk("proto_err_cleared", proto_err, 0);
        chk("proto_clr_in_count", in_count, 0);
        chk("proto_clr_out_count", out_count, 0);
        chk("proto_clr_level", level, 4);
    endtask

    task automatic test_drain();
        m_ready = 1'b1;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        m_ready = 1'b0;
        chk("drain_out_count", out_count, 4);
        chk("drain_level", level, 0);
        chk("drain_m_valid", m_valid, 0);
        chk("drain_m_data", m_data, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic stream(input int n, input string tag);
        int max_lvl = 0;
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(i);
            tick();
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        chk({tag, "_max_level"}, max_lvl, 1);
        chk({tag, "_end_level"}, level, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic test_back_to_back();
        clr_pulse();
        stream(10, "b2b");
        chk("b2b_in_count", in_count, 10);
        chk("b2b_out_count", out_count, 10);
    endtask

    task automatic test_saturate();
        clr_pulse();
        stream(20, "sat");
        chk("sat_in_count", in_count, 15);
        chk("sat_out_count", out_count, 15);
    endtask

    task automatic test_clr_vs_push();
        clr_pulse();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h9C;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        s_valid = 1'b0;
        chk("clr_override_in_count", in_count, 0);
        chk("clr_keeps_push_level", level, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("clr_pop_out_count", out_count, 1);
        chk("clr_pop_level", level, 0);
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(8'hC0 + i);
            tick();
        end
        s_valid = 1'b0;
        chk("mid_level_before", level, 3);
        #2;
        irst = 1'b1;
        #1;
        chk("mid_async_level", level, 0);
        chk("mid_async_m_valid", m_valid, 0);
        chk("mid_async_m_data", m_data, 0);
        chk("mid_async_s_ready", s_ready, 0);
        tick();
        irst = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hA5;
        tick();
        s_valid = 1'b0;
        chk("post_rst_level", level, 1);
        chk("post_rst_m_valid", m_valid, 1);
        chk("post_rst_m_data", m_data, 8'hA5);
        chk("post_rst_in_count", in_count, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("post_rst_drain_level", level, 0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_proto();
        test_drain();
        test_back_to_back();
        test_saturate();
        test_clr_vs_push();
        test_reset_mid();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ready_valid_fifo.md
READY_VALID_FIFO -- requirements
Module: ready_valid_fifo

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, storage entries; power of two, >=2.
REQ-003 Parameter CNT_W, default 16, width of each transfer counter.
REQ-004 Let LW = $clog2(DEPTH)+1.
REQ-005 iclk  input  1  sole clock; all state updates on posedge iclk.
REQ-006 irst  input  1  reset, asynchronous, active-high.
REQ-007 s_data  input  DATA_W  upstream payload.
REQ-008 s_valid  input  1  upstream master_valid.
REQ-009 s_ready  output  1  slave_ready toward upstream.
REQ-010 m_data  output  DATA_W  downstream payload.
REQ-011 m_valid  output  1  master_valid toward downstream.
REQ-012 m_ready  input  1  downstream slave_ready.
REQ-013 clr_stats  input  1  synchronous clear of counters and error flag.
REQ-014 level  output  LW  entries currently stored, 0..DEPTH.
REQ-015 in_count  output  CNT_W  accepted upstream transfers.
REQ-016 out_count  output  CNT_W  completed downstream transfers.
REQ-017 proto_err  output  1  sticky upstream protocol-violation flag.

Function
REQ-018 Push occurs at a posedge where s_valid && s_ready; pop occurs at a posedge where m_valid && m_ready.
REQ-019 s_ready SHALL equal (level != DEPTH) && !irst, combinationally; no bypass when full, even if a pop occurs in the same cycle.
REQ-020 m_valid SHALL equal (level != 0); m_data SHALL show the oldest entry (first-word fall-through), and 0 when m_valid=0.
REQ-021 Latency: a word pushed at edge N SHALL be visible on m_data/m_valid immediately after edge N if the FIFO was empty.
REQ-022 Order SHALL be strictly FIFO; no word dropped or duplicated.
REQ-023 Simultaneous push and pop SHALL leave level unchanged, with both pointers advancing.
REQ-024 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 level SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise.
REQ-026 in_count increments on each push; out_count increments on each pop; both saturate at 2^CNT_W-1.
REQ-027 Protocol check: if the previous edge saw s_valid && !s_ready and the current edge sees s_valid=0 or s_data changed, proto_err SHALL set to 1 and hold.
REQ-028 clr_stats=1 at an edge SHALL zero in_count, out_count and proto_err; it overrides any same-cycle increment or error set; FIFO contents are unaffected.
REQ-029 Storage array need not be reset; only pointers, level, counters, flags and the check history register are reset.

Reset
REQ-030 While irst=1: level=0, m_valid=0, m_data=0, s_ready=0, in_count=0, out_count=0, proto_err=0, pointers=0, check history cleared.
REQ-031 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronously).
REQ-032 First push is possible at the first posedge after irst deasserts.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33,0x44 with m_ready=0 (DEPTH=4) -> level=4, s_ready=0, in_count=4; a fifth s_valid is held, not accepted.
REQ-034 From full, m_ready=1 for 4 cycles with s_valid=0 -> m_data sequence 0x11,0x22,0x33,0x44, out_count=4, level=0, m_valid=0.
REQ-035 Continuous s_valid and m_ready for 10 words 0x00..0x09 -> level stays at most 1, in order, pointers wrap, in_count=out_count=10.
REQ-036 Fill to full, drop s_valid while s_ready=0 -> proto_err=1; then clr_stats pulse -> proto_err=0, counters=0, level still 4.
REQ-037 CNT_W=4, 20 transfers -> in_count and out_count saturate at 15.
REQ-038 Assert irst with level=3 -> level=0, m_valid=0 immediately, before the next posedge.
